// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: PS/2 mouse command/reply bytes, sequencer states and command table
package ps2_mouse_pkg;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SETRATE = 8'hF3;
  localparam logic [7:0] RATE_100    = 8'h64;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_ID_STD  = 8'h00;
  localparam int MS_W = 16;
  localparam logic [3:0][7:0] CMD_TABLE = {CMD_ENABLE, RATE_100, CMD_SETRATE, CMD_RESET};
  typedef enum logic [3:0] {
    ST_POWERUP,
    ST_SEND,
    ST_WAIT_BUSY_HI,
    ST_WAIT_BUSY_LO,
    ST_WAIT_ACK,
    ST_WAIT_BAT,
    ST_WAIT_ID,
    ST_NEXT,
    ST_FAULT,
    ST_DONE,
    ST_FAIL
  } state_t;
endpackage

// File: rtl/ps2_mouse_init_seq_if.sv
// ps2_mouse_init_seq_if: receiver, transmitter and forwarding signals around the init sequencer
interface ps2_mouse_init_seq_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic       tx_error;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] fwd_data;
  logic       fwd_valid;
  modport master (
    input  rx_data, rx_valid, tx_busy, tx_error,
    output tx_data, tx_load, fwd_data, fwd_valid
  );
  modport slave (
    output rx_data, rx_valid, tx_busy, tx_error,
    input  tx_data, tx_load, fwd_data, fwd_valid
  );
endinterface

// File: rtl/ps2_ms_timer.sv
// ps2_ms_timer: free 1 ms prescaler plus tick counter, restarted by clr, flags when limit ticks elapsed
module ps2_ms_timer #(
  parameter int PRESCALE = 28000,
  parameter int MS_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [MS_W-1:0] limit,
  output logic            elapsed
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  logic [MS_W-1:0] ms;
  logic tick;
  assign tick = pre == PW'(PRESCALE - 1);
  assign elapsed = ms >= limit;
  // ms saturates so long idle states never wrap back below a limit
  always_ff @(posedge clk)
    if (rst || clr) begin
      pre <= '0;
      ms <= '0;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick && ms != '1) ms <= ms + MS_W'(1);
    end
endmodule

// File: rtl/ps2_mouse_init_seq.sv
// ps2_mouse_init_seq: PS/2 mouse bring-up (FF, F3 64, F4) with reply checking, retries and
// gating of received bytes until init completes
module ps2_mouse_init_seq
  import ps2_mouse_pkg::*;
#(
  parameter int CLK_HZ = 28000000,
  parameter int POWERUP_MS = 600,
  parameter int REPLY_MS = 25,
  parameter int BAT_MS = 750,
  parameter int RETRIES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  ps2_mouse_init_seq_if.master        bus,
  output logic                        init_done,
  output logic                        init_fail,
  output logic [1:0]                  retry_cnt
);
  state_t state, state_n;
  logic [1:0] idx, idx_n, retry_n;
  logic resend, resend_n;
  logic [MS_W-1:0] limit;
  logic timeout, fwd;
  assign limit = state == ST_POWERUP ? MS_W'(POWERUP_MS) :
                 (state == ST_WAIT_BAT || state == ST_WAIT_ID) ? MS_W'(BAT_MS) : MS_W'(REPLY_MS);
  assign fwd = bus.rx_valid && state == ST_DONE && !start;
  ps2_ms_timer #(.PRESCALE(CLK_HZ / 1000), .MS_W(MS_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(start || state_n != state),
    .limit(limit),
    .elapsed(timeout)
  );
  // a received byte always wins over a timeout in the same cycle
  always_comb begin
    state_n = state;
    idx_n = idx;
    retry_n = retry_cnt;
    resend_n = resend;
    case (state)
      ST_POWERUP: if (timeout) begin
        state_n = ST_SEND;
        idx_n = '0;
      end
      ST_SEND: state_n = ST_WAIT_BUSY_HI;
      ST_WAIT_BUSY_HI: state_n = bus.tx_busy ? ST_WAIT_BUSY_LO : timeout ? ST_FAULT : state;
      ST_WAIT_BUSY_LO: state_n = !bus.tx_busy ? (bus.tx_error ? ST_FAULT : ST_WAIT_ACK) :
                                 timeout ? ST_FAULT : state;
      ST_WAIT_ACK: if (bus.rx_valid) begin
        state_n = bus.rx_data == RSP_ACK ? (idx == 2'd0 ? ST_WAIT_BAT : ST_NEXT) : ST_FAULT;
        resend_n = bus.rx_data == RSP_RESEND;
      end else if (timeout) state_n = ST_FAULT;
      ST_WAIT_BAT: state_n = bus.rx_valid ? (bus.rx_data == RSP_BAT_OK ? ST_WAIT_ID : ST_FAULT) :
                             timeout ? ST_FAULT : state;
      ST_WAIT_ID: state_n = bus.rx_valid ? (bus.rx_data == RSP_ID_STD ? ST_NEXT : ST_FAULT) :
                            timeout ? ST_FAULT : state;
      ST_NEXT: begin
        state_n = idx == 2'd3 ? ST_DONE : ST_SEND;
        idx_n = idx == 2'd3 ? idx : idx + 2'd1;
      end
      ST_FAULT: begin
        resend_n = 1'b0;
        state_n = retry_cnt == 2'(RETRIES) ? ST_FAIL : ST_SEND;
        retry_n = retry_cnt == 2'(RETRIES) ? retry_cnt : retry_cnt + 2'd1;
        idx_n = resend ? idx : 2'd0;
      end
      default: ;
    endcase
    if (start) begin
      state_n = ST_POWERUP;
      idx_n = '0;
      retry_n = '0;
      resend_n = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_POWERUP;
      idx <= '0;
      retry_cnt <= '0;
      resend <= 1'b0;
      bus.tx_data <= '0;
      bus.tx_load <= 1'b0;
      bus.fwd_data <= '0;
      bus.fwd_valid <= 1'b0;
      init_done <= 1'b0;
      init_fail <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      retry_cnt <= retry_n;
      resend <= resend_n;
      bus.tx_load <= state_n == ST_SEND;
      if (state_n == ST_SEND) bus.tx_data <= CMD_TABLE[idx_n];
      bus.fwd_valid <= fwd;
      if (fwd) bus.fwd_data <= bus.rx_data;
      init_done <= state_n == ST_DONE;
      init_fail <= state_n == ST_FAIL;
    end
endmodule
